dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer placed in front of the single-port word-aligned data memory of the MIPS core. It shares the memory between the CPU load/store port (port 0) and a secondary requester such as a DMA or debug loader (port 1). Each transfer follows a req/ack handshake, runs a fixed three-state sequence and is range- and alignment-checked before any write reaches the memory.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port req/ack arbiter and access sequencer in front of the
//            single-port, word-aligned data memory.  Port 0 is the CPU
//            load/store port, port 1 a secondary requester (DMA/debug).
//            Each transfer runs IDLE -> ACCESS -> DONE and is range- and
//            alignment-checked before any write reaches the memory.
// Options  : DMEM_ARB_RR_EN - round-robin arbitration (default: port 0 wins)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_w_enable,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              busy
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ACCESS = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [31:0] C_DEPTH  = 32'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_grant;       // port owning the current transfer
    logic              r_last_grant;  // port that completed the last transfer
    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              w_winner;
    logic              w_any_req;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_err;

    assign w_any_req = p0_req | p1_req;

    // Winner selection; with no request the value is unused and simply
    // follows the last grant.
`ifdef DMEM_ARB_RR_EN
    always_comb begin
        if (p0_req && p1_req) w_winner = ~r_last_grant;
        else if (p0_req)      w_winner = 1'b0;
        else if (p1_req)      w_winner = 1'b1;
        else                  w_winner = r_last_grant;
    end
`else
    always_comb begin
        if (p0_req)      w_winner = 1'b0;
        else if (p1_req) w_winner = 1'b1;
        else             w_winner = r_last_grant;
    end
`endif

    // Word index compared at full 30-bit width so huge addresses never alias.
    assign w_misaligned   = |r_addr[1:0];
    assign w_out_of_range = {2'b00, r_addr[31:2]} >= C_DEPTH;
    assign w_err          = w_misaligned | w_out_of_range;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: fixed three-step sequence once a request is seen.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Command latch, per-port read data capture and grant history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= '0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_winner;
                        r_we    <= w_winner ? p1_we    : p0_we;
                        r_addr  <= w_winner ? p1_addr  : p0_addr;
                        r_wdata <= w_winner ? p1_wdata : p0_wdata;
                    end
                end
                S_ACCESS: begin
                    // Good writes leave the port's read data untouched.
                    if (w_err || !r_we) begin
                        if (r_grant) r_p1_rdata <= w_err ? '0 : mem_r_data;
                        else         r_p0_rdata <= w_err ? '0 : mem_r_data;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_grant;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registers only; no path from req to ack or mem_*.
    always_comb begin
        busy         = (r_state != S_IDLE);
        mem_w_enable = (r_state == S_ACCESS) & r_we & ~w_err;
        mem_address  = r_addr;
        mem_w_data   = r_wdata;
        p0_ack       = (r_state == S_DONE) & ~r_grant;
        p1_ack       = (r_state == S_DONE) &  r_grant;
        p0_err       = p0_ack & w_err;
        p1_err       = p1_ack & w_err;
        p0_rdata     = r_p0_rdata;
        p1_rdata     = r_p1_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: directed vector table,
//            contention ordering, randomized traffic against a transaction
//            level reference model, and reset during a write.
// Options  : DMEM_ARB_RR_EN selects the expected arbitration policy
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DEPTH  = 64;
    localparam int DATA_W = 32;
    localparam int AW     = $clog2(DEPTH);
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [31:0]       addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic              p0_ack, p1_ack, p0_err, p1_err;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_w_enable;
    logic [31:0]       mem_address;
    logic [DATA_W-1:0] mem_w_data;
    logic [DATA_W-1:0] mem_r_data;
    logic              busy;

    logic [1:0]        ackv;
    logic [1:0]        errv;
    logic [DATA_W-1:0] rdv [2];

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_rd  [2];
    int                lg_m;
    int                exp_wen;
    int                wen_cnt;
    int                wen_oob;
    int                n_pass;
    int                n_total;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_w_enable(mem_w_enable), .mem_address(mem_address),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .busy(busy)
    );

    assign ackv   = {p1_ack, p0_ack};
    assign errv   = {p1_err, p0_err};
    assign rdv[0] = p0_rdata;
    assign rdv[1] = p1_rdata;

    // Behavioural memory with combinational read; counts write-enable cycles.
    assign mem_r_data = ({2'b00, mem_address[31:2]} < 32'(DEPTH)) ?
                        mem[mem_address[AW+1:2]] : 32'hBAD0_BAD0;
    initial begin
        wen_cnt = 0;
        wen_oob = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            if (mem_w_enable === 1'b1) begin
                wen_cnt++;
                if ({2'b00, mem_address[31:2]} < 32'(DEPTH))
                    mem[mem_address[AW+1:2]] <= mem_w_data;
                else
                    wen_oob++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Transaction-level model: applies one completed access in grant order.
    function automatic void model(input int p, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, output logic e,
                                  output logic [31:0] rd);
        e = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
        if (!e && w) begin
            ref_mem[a[AW+1:2]] = d;
            exp_wen++;
        end
        rd = e ? 32'd0 : (w ? exp_rd[p] : ref_mem[a[AW+1:2]]);
        exp_rd[p] = rd;
        lg_m = p;
    endfunction

    // Issue one request on each enabled port (same cycle) and check results.
    task automatic run(input logic [1:0] en, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1,
                       output logic le, output logic [31:0] lrd);
        int n, got, need, first, base, ew;
        logic e;
        logic [31:0] rd;
        logic [31:0] aa [2];
        logic [31:0] dd [2];
        logic [1:0]  drop;
        aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
        need  = int'(en[0]) + int'(en[1]);
        if (en == 2'b11) first = RR ? ((lg_m == 1) ? 0 : 1) : 0;
        else             first = en[0] ? 0 : 1;
        base = wen_cnt;
        ew   = exp_wen;
        le   = 1'b0;
        lrd  = '0;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            if (en[p]) begin
                req[p] = 1'b1; we[p] = w[p]; addr[p] = aa[p]; wdata[p] = dd[p];
            end
        end
        n = 0; got = 0;
        while (got < need && n < 40) begin
            @(negedge clk);
            n++;
            drop = 2'b00;
            for (int p = 0; p < 2; p++) begin
                if (ackv[p] === 1'b1) begin
                    chk("ack_port", 32'(p), 32'((got == 0) ? first : 1 - first));
                    chk("ack_cycle", 32'(n), 32'(3 * (got + 1)));
                    model(p, w[p], aa[p], dd[p], e, rd);
                    chk("err", 32'(errv[p]), 32'(e));
                    chk("rdata", rdv[p], rd);
                    le = errv[p]; lrd = rdv[p];
                    got++;
                    drop[p] = 1'b1;
                end
            end
            if (drop != 2'b00) begin
                @(posedge clk); #1;
                req = req & ~drop;
            end
        end
        if (got < need) begin
            chk("ack_timeout", 32'(got), 32'(need));
            req = 2'b00;
        end
        chk("wen_cycles", 32'(wen_cnt - base), 32'(exp_wen - ew));
    endtask

    function automatic logic [31:0] gen_addr();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       gen_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            1:       gen_addr = (32'(DEPTH) + 32'($urandom_range(0, 1000))) << 2;
            2:       gen_addr = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
            default: gen_addr = 32'($urandom_range(0, 15)) << 2;
        endcase
    endfunction

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        le, bad;
        logic [31:0] lrd;
        int          cnt [2];
        int          n, nacks, lastn;
        int          exp_order [8];
        logic [1:0]  drop;

        n_pass = 0; n_total = 0; exp_wen = 0; lg_m = 1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        req = 2'b00; we = 2'b00;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        // Asynchronous reset values, before any clock edge.
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_acks",  32'({p1_ack, p0_ack, p1_err, p0_err}), 0);
        chk("rst_rdata", p0_rdata | p1_rdata, 0);
        chk("rst_wen",   32'(mem_w_enable), 0);
        chk("rst_addr",  mem_address, 0);
        chk("rst_wdata", mem_w_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle for ten cycles without requests.
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bad = bad | busy | p0_ack | p1_ack | mem_w_enable;
        end
        chk("idle_quiet", 32'(bad), 0);

        // Directed vectors.
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_0102, 32'hCAFE_0001, 1'b1, 32'h0000_0000};
        tbl[3]  = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_0002, 1'b1, 32'h0000_0000};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0000};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h1234_5678};
        tbl[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hBADB_AD00, 1'b1, 32'h0000_0000};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h1234_5678};
        tbl[10] = '{1'b1, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h1234_5678};
        tbl[11] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        for (int i = 0; i < 13; i++) begin
            run(tbl[i].port ? 2'b10 : 2'b01, {tbl[i].we, tbl[i].we},
                tbl[i].addr, tbl[i].wdata, tbl[i].addr, tbl[i].wdata, le, lrd);
            chk("tbl_err",   32'(le), 32'(tbl[i].exp_err));
            chk("tbl_rdata", lrd, tbl[i].exp_rdata);
        end
        chk("no_oob_write", 32'(wen_oob), 0);

        // Both ports hold four back-to-back reads each from the same cycle.
        for (int i = 0; i < 8; i++)
            exp_order[i] = RR ? (i % 2) : ((i < 4) ? 0 : 1);
        cnt[0] = 0; cnt[1] = 0; n = 0; nacks = 0; lastn = 0;
        @(posedge clk); #1;
        we = 2'b00; addr[0] = 32'h0; addr[1] = 32'h0; req = 2'b11;
        while (nacks < 8 && n < 60) begin
            @(negedge clk);
            n++;
            drop = 2'b00;
            for (int p = 0; p < 2; p++) begin
                if (ackv[p] === 1'b1) begin
                    chk("arb_order", 32'(p), 32'(exp_order[nacks]));
                    chk("arb_spacing", 32'(n - lastn), 3);
                    chk("arb_rdata", rdv[p], ref_mem[0]);
                    exp_rd[p] = ref_mem[0];
                    lg_m = p;
                    lastn = n;
                    nacks++;
                    cnt[p]++;
                    if (cnt[p] == 4) drop[p] = 1'b1;
                end
            end
            if (drop != 2'b00) begin
                @(posedge clk); #1;
                req = req & ~drop;
            end
        end
        chk("arb_count", 32'(nacks), 8);
        req = 2'b00;

        // Randomized traffic, including same-cycle contention.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] en;
            int m;
            m  = int'($urandom_range(0, 2));
            en = (m == 0) ? 2'b01 : ((m == 1) ? 2'b10 : 2'b11);
            run(en, 2'($urandom), gen_addr(), $urandom, gen_addr(), $urandom, le, lrd);
        end
        chk("rand_no_oob_write", 32'(wen_oob), 0);

        // Reset asserted during the ACCESS cycle of a write.
        run(2'b01, 2'b01, 32'h14, 32'h1111_1111, 32'h0, 32'h0, le, lrd);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'h2222_2222;
        @(posedge clk); #1;
        chk("access_wen", 32'(mem_w_enable), 1);
        chk("access_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_wen", 32'(mem_w_enable), 0);
        chk("abort_busy", 32'(busy), 0);
        req[0] = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bad = bad | p0_ack | p1_ack;
        end
        chk("abort_no_ack", 32'(bad), 0);
        chk("abort_rdata", p0_rdata | p1_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        lg_m = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        chk("abort_word_kept", mem[5], 32'h1111_1111);
        run(2'b01, 2'b00, 32'h14, 32'h0, 32'h0, 32'h0, le, lrd);
        chk("abort_readback", lrd, 32'h1111_1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
